// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C write-only target receiver.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one I2C pin plus a history flop for edge detection.
module i2c_sync_edge (
  input  logic clk100mhz,
  input  logic reset,
  input  logic pin_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Flops reset high so an idle bus never looks like an edge after reset.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level  = sync_q;
  assign rise_c = sync_q & ~hist_q;
  assign fall_c = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: ACKs writes to OWN_ADDR and streams received data bytes out.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR = 7'h50
) (
  input  logic                  clk100mhz,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  input  logic                  rx_full,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  busy
);

  logic scl_level, scl_rise_c, scl_fall_c;
  logic sda_level, sda_rise_c, sda_fall_c;

  i2c_sync_edge u_scl_sync (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .pin_in    (scl_in),
    .level     (scl_level),
    .rise_c    (scl_rise_c),
    .fall_c    (scl_fall_c)
  );

  i2c_sync_edge u_sda_sync (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .pin_in    (sda_in),
    .level     (sda_level),
    .rise_c    (sda_rise_c),
    .fall_c    (sda_fall_c)
  );

  i2c_state_e                  state_q, state_d;
  logic [I2C_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-2:0]       shift_q, shift_d;
  logic                        nack_q, nack_d;
  logic                        sda_oe_q, sda_oe_d;
  logic [I2C_BYTE_W-1:0]       rx_data_q, rx_data_d;
  logic                        rx_valid_q, rx_valid_d;
  logic                        start_det_q, start_det_d;
  logic                        stop_det_q, stop_det_d;
  logic                        busy_q, busy_d;

  logic                        scl_hi_c, start_c, stop_c, last_bit_c;
  logic [I2C_BYTE_W-1:0]       byte_c;

  // SCL high in this and the previous sample; false whenever SCL itself just moved.
  assign scl_hi_c   = scl_level & ~scl_rise_c;
  assign start_c    = sda_fall_c & scl_hi_c;
  assign stop_c     = sda_rise_c & scl_hi_c;
  assign byte_c     = {shift_q, sda_level};
  assign last_bit_c = (bit_cnt_q == I2C_CNT_W'(I2C_BYTE_W - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    busy_d      = busy_q;

    if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_c) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      start_det_d = 1'b1;
    end else begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise_c) begin
            shift_d   = byte_c[I2C_BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + I2C_CNT_W'(1);
            if (last_bit_c) begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                state_d = (byte_c[I2C_BYTE_W-1:1] == OWN_ADDR && !byte_c[0]) ? ADDR_ACK : IGNORE;
              end else begin
                rx_data_d  = byte_c;
                rx_valid_d = 1'b1;
                nack_d     = rx_full;
                state_d    = DATA_ACK;
              end
            end
          end
        end
        // First SCL fall drives the ACK, the next one releases it.
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (sda_oe_q) begin
              sda_oe_d = 1'b0;
              state_d  = DATA;
            end else begin
              sda_oe_d = 1'b1;
            end
          end
        end
        DATA_ACK: begin
          if (nack_q) begin
            state_d = IGNORE;
          end else if (scl_fall_c) begin
            if (sda_oe_q) begin
              sda_oe_d = 1'b0;
              state_d  = DATA;
            end else begin
              sda_oe_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a 400 kHz bus master plus a transaction-level model of the target.
module tb_i2c_target_rx;

  logic       clk100mhz = 1'b0;
  logic       reset;
  logic       scl_drv, sda_drv, rx_full;
  logic       scl_in, sda_in;
  logic       sda_oe, rx_valid, start_det, stop_det, busy;
  logic [7:0] rx_data;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5ns clk100mhz = ~clk100mhz;

  i2c_target_rx #(.OWN_ADDR(7'h50)) dut (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .rx_full   (rx_full),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  // Transaction model: 0 idle, 1 expecting address, 2 receiving data, 3 ignoring.
  int         mode = 0;
  logic       exp_busy = 1'b0;
  logic       exp_oe = 1'b0;
  logic       cur_ack = 1'b0;
  logic [7:0] exp_q[$];

  int tests = 0, fails = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0;
  int cyc = 0, last_chg = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk100mhz) cyc++;
  always @(scl_in or sda_in or reset) last_chg = cyc;

  // Per-cycle compare: strobes against the model queue, levels once the bus has settled.
  always @(negedge clk100mhz) begin
    if (!reset) begin
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (rx_valid) begin
        n_rxv++;
        check("rx_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (cyc - last_chg > 6) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("sda_oe", 32'(sda_oe), 32'(exp_oe));
      end
    end
  end

  task automatic model_byte(input logic [7:0] b);
    cur_ack = 1'b0;
    if (mode == 1) begin
      cur_ack = (b[7:1] == 7'h50) && !b[0];
      mode    = cur_ack ? 2 : 3;
    end else if (mode == 2) begin
      exp_q.push_back(b);
      cur_ack = !rx_full;
      if (!cur_ack) mode = 3;
    end
  endtask

  task automatic do_start();
    exp_busy = 1'b1; mode = 1;
    sda_drv = 1'b0; #625ns;
    scl_drv = 1'b0; #625ns;
  endtask

  task automatic do_rstart();
    sda_drv = 1'b1; #625ns;
    scl_drv = 1'b1; #625ns;
    exp_busy = 1'b1; exp_oe = 1'b0; mode = 1;
    sda_drv = 1'b0; #625ns;
    scl_drv = 1'b0; #625ns;
  endtask

  task automatic do_stop();
    sda_drv = 1'b0; #625ns;
    scl_drv = 1'b1; #625ns;
    exp_busy = 1'b0; exp_oe = 1'b0; mode = 0;
    sda_drv = 1'b1; #625ns;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i]; #625ns;
      scl_drv = 1'b1; #1250ns;
      scl_drv = 1'b0; #625ns;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_clk);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; #625ns;
      scl_drv = 1'b1;
      if (i == 0) model_byte(b);
      #1250ns;
      scl_drv = 1'b0;
      if (i == 0) exp_oe = cur_ack;
      #625ns;
    end
    if (ack_clk) begin
      sda_drv = 1'b1; #625ns;
      scl_drv = 1'b1; #625ns;
      check("ack_on_wire", 32'(!sda_in), 32'(cur_ack));
      #625ns;
      scl_drv = 1'b0; exp_oe = 1'b0; #625ns;
    end
  endtask

  task automatic clear_counts();
    n_start = 0; n_stop = 0; n_rxv = 0;
  endtask

  task automatic expect_counts(input string name, input int s, input int p, input int r);
    check({name, "_starts"}, 32'(n_start), 32'(s));
    check({name, "_stops"},  32'(n_stop),  32'(p));
    check({name, "_rxv"},    32'(n_rxv),   32'(r));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; rx_full = 1'b0;
    #23ns;
    check("rst_sda_oe",    32'(sda_oe),    32'd0);
    check("rst_rx_data",   32'(rx_data),   32'd0);
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_start_det", 32'(start_det), 32'd0);
    check("rst_stop_det",  32'(stop_det),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    #30ns reset = 1'b0;
    #1us;
    expect_counts("idle_release", 0, 0, 0);

    // Simultaneous SCL and SDA fall must not read as a START.
    clear_counts();
    scl_drv = 1'b0; sda_drv = 1'b0; #1250ns;
    sda_drv = 1'b1; #625ns;
    scl_drv = 1'b1; #1250ns;
    expect_counts("same_cycle", 0, 0, 0);
    check("same_cycle_busy", 32'(busy), 32'd0);

    // Basic write: address 0x50+W then 0xA5.
    clear_counts();
    do_start(); send_byte(8'hA0, 1); send_byte(8'hA5, 1); do_stop();
    expect_counts("write_a5", 1, 1, 1);
    check("write_a5_data", 32'(rx_data), 32'hA5);

    // Wrong address is ignored.
    clear_counts();
    do_start(); send_byte(8'hA2, 1);
    check("wrong_addr_busy", 32'(busy), 32'd1);
    send_byte(8'h33, 1); do_stop();
    expect_counts("wrong_addr", 1, 1, 0);

    // Read to own address is NACKed.
    clear_counts();
    do_start(); send_byte(8'hA1, 1);
    check("read_busy", 32'(busy), 32'd1);
    do_stop();
    check("read_busy_after", 32'(busy), 32'd0);
    expect_counts("read", 1, 1, 0);

    // Backpressure: second byte delivered but NACKed, later bytes ignored.
    clear_counts();
    do_start(); send_byte(8'hA0, 1); send_byte(8'h11, 1);
    rx_full = 1'b1; send_byte(8'h22, 1); send_byte(8'h33, 1);
    rx_full = 1'b0; do_stop();
    expect_counts("full", 1, 1, 2);
    check("full_last_data", 32'(rx_data), 32'h22);

    // Repeated START after a partial byte.
    clear_counts();
    do_start(); send_byte(8'hA0, 1); send_bits(8'hF0, 4);
    do_rstart(); send_byte(8'hA0, 1); send_byte(8'h5A, 1); do_stop();
    expect_counts("rstart", 2, 1, 1);
    check("rstart_data", 32'(rx_data), 32'h5A);

    // Reset while the address ACK is being driven.
    clear_counts();
    do_start(); send_byte(8'hA0, 0);
    #300ns;
    check("oe_before_rst", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    mode = 0; exp_busy = 1'b0; exp_oe = 1'b0;
    #1ns;
    check("mid_rst_sda_oe",   32'(sda_oe),   32'd0);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_rx_data",  32'(rx_data),  32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    #200ns scl_drv = 1'b1;
    #200ns sda_drv = 1'b1;
    #200ns reset = 1'b0;
    clear_counts();
    #2us;
    expect_counts("post_rst", 0, 0, 0);
    do_start(); send_byte(8'hA0, 1); send_byte(8'h3C, 1); do_stop();
    expect_counts("post_rst_xfer", 1, 1, 1);
    check("post_rst_data", 32'(rx_data), 32'h3C);

    #1us;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter OWN_ADDR, default 7'h50, the 7-bit target address this block answers to.
REQ-002 clk100mhz  input  1  system clock, 100 MHz.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 scl_in  input  1  raw I2C SCL pin level, asynchronous to clk100mhz.
REQ-005 sda_in  input  1  raw I2C SDA pin level, asynchronous to clk100mhz.
REQ-006 rx_full  input  1  consumer cannot accept a byte; the next data byte is NACKed.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release SDA.
REQ-008 rx_data  output  8  last received data byte, MSB first on the wire.
REQ-009 rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-010 start_det  output  1  one-cycle strobe on START or repeated START.
REQ-011 stop_det  output  1  one-cycle strobe on STOP.
REQ-012 busy  output  1  high from START until STOP.

Function
REQ-013 scl_in and sda_in SHALL each pass through a 2-FF synchronizer, then a history register for edge detection; a pin change SHALL be acted on no later than the 3rd clk100mhz rising edge.
REQ-014 START SHALL be synced SDA 1->0 while synced SCL is 1 in both current and previous sample.
REQ-015 STOP SHALL be synced SDA 0->1 while synced SCL is 1 in both current and previous sample.
REQ-016 If SCL and SDA change in the same sample cycle, only the SCL edge SHALL be processed; no START or STOP is flagged.
REQ-017 SDA SHALL be sampled on a synced SCL rising edge and shifted in MSB first; the bit counter runs 0..7.
REQ-018 States SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-019 IDLE->ADDR on START; bit counter cleared; busy=1.
REQ-020 ADDR: after the 8th bit, if byte[7:1]==OWN_ADDR and byte[0]==0 (write), go to ADDR_ACK; otherwise go to IGNORE (reads and other addresses are NACKed).
REQ-021 ADDR_ACK: assert sda_oe on the next SCL falling edge; release it on the following SCL falling edge; then go to DATA.
REQ-022 DATA: after the 8th bit, update rx_data, pulse rx_valid for exactly one cycle, and go to DATA_ACK. rx_full is sampled in that same cycle.
REQ-023 DATA_ACK: if sampled rx_full=0, drive the ACK as in REQ-021 and return to DATA. If rx_full=1, keep sda_oe=0 (NACK), still pulse rx_valid, and go to IGNORE.
REQ-024 IGNORE: sda_oe=0; wait only for START or STOP.
REQ-025 START in any non-IDLE state (repeated START) SHALL go to ADDR, clear the bit counter, release sda_oe the same cycle, and pulse start_det.
REQ-026 STOP in any state SHALL go to IDLE, release sda_oe, clear busy, and pulse stop_det; a partial byte is discarded with no rx_valid.
REQ-027 sda_oe SHALL change only on a synced SCL falling edge, or on START/STOP/reset.

Reset
REQ-028 Reset SHALL force state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, start_det=0, stop_det=0, busy=0, bit counter 0.
REQ-029 Synchronizer flops SHALL reset to 1 (idle bus), so reset release on an idle bus produces no spurious START or STOP.
REQ-030 Reset asserted mid-transfer SHALL release SDA within the same cycle; after release the block waits for a fresh START.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enum typedef, I2C_ADDR_W=7, and I2C_BYTE_W=8.
REQ-032 One sub-module, i2c_sync_edge, SHALL implement the 2-FF synchronizer plus rise/fall detect; it is instantiated once for SCL and once for SDA.

Verification
REQ-033 START, addr 0x50+W, data 0xA5, STOP at 400 kHz SCL -> ACK on both bytes, rx_valid once with rx_data=0xA5, start_det and stop_det each pulse once.
REQ-034 Addr 0x51+W -> NACK (sda_oe stays 0 for the whole transfer), no rx_valid, busy=1 until STOP.
REQ-035 Addr 0x50+R -> NACK, state IGNORE; the following STOP returns busy to 0.
REQ-036 Write 0x11, then 0x22 with rx_full=1 -> first byte ACKed, second byte rx_valid with 0x22 but NACKed, further bytes ignored.
REQ-037 Repeated START after 4 data bits -> no rx_valid, start_det pulses, a new address 0x50+W is ACKed.
REQ-038 Reset pulsed while sda_oe=1 during ACK -> sda_oe=0 the same cycle, all outputs return to reset values, no spurious START/STOP after release.
